viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Survivor-memory and traceback stage for the 64-state (K=7) Viterbi decoder.
- Buffers one frame of DEPTH 64-bit decision vectors from the ACS array.
- Walks the trellis backwards and drives the current 6-bit state index on tb_state, which feeds the 6-to-64 one-hot decoder used for survivor selection.
- Emits the decoded bits in forward time order over a valid/ready stream.

Parameters:
- DEPTH, 32, trellis steps per frame. Must be a power of two, at least 2.
- AW, 5, address width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dec_valid  input  1  decision vector valid.
- dec_ready  output  1  block can accept a decision vector.
- dec_in  input  64  decision bits, bit s belongs to state s.
- start_state  input  6  traceback start state (best-metric state from ACS).
- tb_state  output  6  current traceback state index, feeds the one-hot decoder.
- tb_active  output  1  tb_state is meaningful this cycle (TRACE state).
- bit_valid  output  1  decoded bit valid.
- bit_ready  input  1  downstream accepts the bit.
- bit_out  output  1  decoded bit.
- bit_last  output  1  last bit of the frame.
- busy  output  1  high in TRACE and EMIT.

Behaviour:
- FSM states: FILL, TRACE, EMIT. Reset enters FILL.
- Reset values: dec_ready=0 during reset, then 1 in FILL; tb_state=0; tb_active=0; bit_valid=0; bit_out=0; bit_last=0; busy=0; write and read counters=0. Memory contents are don't-care.
- FILL:
  - dec_ready=1.
  - On dec_valid&&dec_ready: mem[wcnt] <= dec_in and wcnt increments.
  - On the handshake with wcnt==DEPTH-1: latch s <= start_state (sampled that same cycle), set k <= DEPTH-1, wcnt <= 0, go to TRACE.
- TRACE:
  - dec_ready=0, busy=1, tb_active=1, tb_state=s.
  - Each cycle: obuf[k] <= s[5]; s <= {s[4:0], mem[k][s]}; k decrements.
  - After the k==0 step, go to EMIT.
  - Takes exactly DEPTH cycles.
- Trellis convention: next state = {u, s[5:1]}, so the bit at step k is the MSB of the state at step k+1, and the predecessor's LSB is the stored decision bit.
- EMIT:
  - bit_valid=1, bit_out=obuf[r], bit_last=(r==DEPTH-1).
  - r advances only when bit_valid&&bit_ready.
  - The handshake on r==DEPTH-1 returns to FILL with r <= 0. dec_ready rises the following cycle.
  - bit_out and bit_last are stable while bit_valid&&!bit_ready.
- Latency:
  - From the last decision handshake to the first bit_valid: DEPTH+1 cycles.
  - With bit_ready held high, the frame drains in DEPTH cycles.
- Overflow is impossible: dec_ready is low outside FILL, and any dec_valid there is ignored.
- dec_valid with dec_ready low has no effect.
- Reset asserted mid-operation: return immediately to FILL, drop bit_valid, discard the partial frame (wcnt=0).
- Arithmetic: k, r and wcnt are AW-bit counters. Transitions are decoded at the terminal counts, not by wrap-around.

Test Plan:
- All-zero decisions, 32 vectors, start_state=0 -> tb_state is 0 for all 32 TRACE cycles; 32 bits of 0 emitted; bit_last on the 32nd bit.
- All-ones decisions, start_state=6'h3F -> tb_state stays 6'h3F; 32 bits of 1 emitted.
- All-zero decisions, start_state=6'h20 -> tb_state sequence is 20,00,00,...; emitted bits are 31 zeros then a 1 (bit 31 = 1); bit_last coincides with the 1.
- Backpressure: bit_ready toggles 1,0,0,1 repeatedly -> no bit lost or duplicated; bit_out is stable while stalled; dec_ready stays 0 until after the bit_last handshake.
- dec_valid held high throughout -> exactly 32 accepts per frame; no writes during TRACE/EMIT; back-to-back frames decode correctly.
- rst_n pulsed low at TRACE cycle 10 -> bit_valid=0 and busy=0 immediately; dec_ready=1 after release; the next full frame decodes correctly.

Source files
------------

// File: rtl/viterbi_traceback_if.sv
// Decision-in / bit-out stream bundle of the Viterbi traceback stage.
// The slave modport is the traceback block; the master modport is its environment.
interface viterbi_traceback_if;
   logic        dec_valid;
   logic        dec_ready;
   logic [63:0] dec_in;
   logic [5:0]  start_state;
   logic [5:0]  tb_state;
   logic        tb_active;
   logic        bit_valid;
   logic        bit_ready;
   logic        bit_out;
   logic        bit_last;
   logic        busy;

   modport slave (
      input  dec_valid, dec_in, start_state, bit_ready,
      output dec_ready, tb_state, tb_active, bit_valid, bit_out, bit_last, busy
   );

   modport master (
      output dec_valid, dec_in, start_state, bit_ready,
      input  dec_ready, tb_state, tb_active, bit_valid, bit_out, bit_last, busy
   );
endinterface

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for the 64-state (K=7) Viterbi decoder: buffers one
// frame of decision vectors, traces it backwards, then streams the bits out in forward order.
module viterbi_traceback #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   viterbi_traceback_if.slave bus
);
   typedef enum logic [1:0] {FILL, TRACE, EMIT} state_t;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [63:0]      r_mem [DEPTH];
   logic [DEPTH-1:0] r_obuf;
   logic [AW-1:0]    r_wcnt;
   logic [AW-1:0]    r_k;
   logic [AW-1:0]    r_r;
   logic [5:0]       r_s;
   logic             r_dec_ready;
   logic             w_dec_fire;
   logic             w_bit_fire;
   logic             w_dec_bit;
   logic             w_tb_active;
   logic             w_busy;
   logic             w_bit_valid;
   logic             w_bit_out;
   logic             w_bit_last;

   assign w_dec_fire = bus.dec_valid && r_dec_ready;
   assign w_bit_fire = (r_state == EMIT) && bus.bit_ready;
   // Survivor decision of the current state: the predecessor's LSB.
   assign w_dec_bit  = r_mem[r_k][r_s];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= FILL;
      else        r_state <= w_next;
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_next      = r_state;
      w_tb_active = 1'b0;
      w_busy      = 1'b0;
      w_bit_valid = 1'b0;
      w_bit_out   = 1'b0;
      w_bit_last  = 1'b0;
      unique case (r_state)
         FILL:  if (w_dec_fire && (r_wcnt == LAST)) w_next = TRACE;
         TRACE: begin
            w_tb_active = 1'b1;
            w_busy      = 1'b1;
            if (r_k == '0) w_next = EMIT;
         end
         EMIT: begin
            w_busy      = 1'b1;
            w_bit_valid = 1'b1;
            w_bit_out   = r_obuf[r_r];
            w_bit_last  = (r_r == LAST);
            if (w_bit_fire && (r_r == LAST)) w_next = FILL;
         end
         default: w_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wcnt      <= '0;
         r_k         <= '0;
         r_r         <= '0;
         r_s         <= '0;
         r_dec_ready <= 1'b0;
      end else begin
         // Registered so it stays low in reset and rises the cycle after FILL is re-entered.
         r_dec_ready <= (w_next == FILL);
         unique case (r_state)
            FILL: begin
               if (w_dec_fire) begin
                  if (r_wcnt == LAST) begin
                     r_wcnt <= '0;
                     r_k    <= LAST;
                     r_s    <= bus.start_state;
                  end else begin
                     r_wcnt <= r_wcnt + AW'(1);
                  end
               end
            end
            TRACE: begin
               r_s <= {r_s[4:0], w_dec_bit};
               r_k <= r_k - AW'(1);
            end
            EMIT: if (w_bit_fire) r_r <= (r_r == LAST) ? '0 : r_r + AW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: pure data storage, always written before it is read in a frame, so it has no reset.
   always_ff @(posedge clk) begin
      if (w_dec_fire)         r_mem[r_wcnt] <= bus.dec_in;
      if (r_state == TRACE)   r_obuf[r_k]   <= r_s[5];
   end

   assign bus.dec_ready = r_dec_ready;
   assign bus.tb_state  = w_tb_active ? r_s : '0;
   assign bus.tb_active = w_tb_active;
   assign bus.busy      = w_busy;
   assign bus.bit_valid = w_bit_valid;
   assign bus.bit_out   = w_bit_out;
   assign bus.bit_last  = w_bit_last;
endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback: table of directed frames plus random frames,
// checked against a trellis walk computed directly from the decision bits.
`timescale 1ns/1ps
module tb_viterbi_traceback;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   viterbi_traceback_if bus ();

   viterbi_traceback #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef enum int {D_ZERO, D_ONE, D_RAND} dfill_t;
   typedef enum int {R_ALWAYS, R_TOGGLE, R_RAND} rmode_t;

   typedef struct {
      dfill_t           fill;
      logic [5:0]       start;
      rmode_t           rmode;
      bit               hold;
      bit               use_model;
      logic [DEPTH-1:0] exp_bits;
   } vec_t;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [63:0]      frame_dec [DEPTH];
   logic [5:0]       frame_start;
   logic [5:0]       exp_state [DEPTH];
   logic [DEPTH-1:0] model_bits;
   logic [DEPTH-1:0] exp_bits;
   vec_t             vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the trellis from the start state, step k emits the MSB of its state.
   task automatic build_model();
      int s;
      int k;
      s = int'(frame_start);
      for (int t = 0; t < DEPTH; t++) begin
         k              = DEPTH - 1 - t;
         exp_state[t]   = 6'(s);
         model_bits[k]  = (s >= 32);
         s              = ((s * 2) % 64) + int'(frame_dec[k][s]);
      end
   endtask

   task automatic fill_frame(input dfill_t f);
      for (int i = 0; i < DEPTH; i++) begin
         case (f)
            D_ZERO:  frame_dec[i] = '0;
            D_ONE:   frame_dec[i] = '1;
            default: frame_dec[i] = {$urandom, $urandom};
         endcase
      end
   endtask

   // Called at a negedge; returns at the negedge of TRACE cycle 0.
   task automatic send_frame(input bit hold);
      int i   = 0;
      int cyc = 0;
      bit fire;
      while (i < DEPTH && cyc < 4 * DEPTH + 20) begin
         bus.dec_valid   = hold ? 1'b1 : ($urandom_range(3) != 0);
         bus.dec_in      = frame_dec[i];
         bus.start_state = (i == DEPTH - 1) ? frame_start : 6'($urandom);
         fire            = bus.dec_valid && bus.dec_ready;
         @(negedge clk);
         cyc++;
         if (fire) i++;
      end
      check("decision beats accepted", i, DEPTH);
      bus.dec_valid   = hold;
      bus.dec_in      = {$urandom, $urandom};
      bus.start_state = 6'($urandom);
   endtask

   task automatic check_trace();
      for (int t = 0; t < DEPTH; t++) begin
         check($sformatf("tb_state t=%0d", t), bus.tb_state, exp_state[t]);
         check($sformatf("trace status t=%0d {active,busy,dec_ready,bit_valid}", t),
               {bus.tb_active, bus.busy, bus.dec_ready, bus.bit_valid}, 4'b1100);
         @(negedge clk);
      end
      check("first bit after trace {active,busy,dec_ready,bit_valid}",
            {bus.tb_active, bus.busy, bus.dec_ready, bus.bit_valid}, 4'b0101);
   endtask

   task automatic recv_bits(input rmode_t rmode);
      int j   = 0;
      int cyc = 0;
      while (j < DEPTH && cyc < 8 * DEPTH) begin
         case (rmode)
            R_ALWAYS: bus.bit_ready = 1'b1;
            R_TOGGLE: bus.bit_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default:  bus.bit_ready = 1'($urandom_range(1));
         endcase
         check($sformatf("bit_valid j=%0d", j), bus.bit_valid, 1'b1);
         check($sformatf("bit_out j=%0d", j), bus.bit_out, exp_bits[j]);
         check($sformatf("bit_last j=%0d", j), bus.bit_last, (j == DEPTH - 1));
         check($sformatf("dec_ready in emit j=%0d", j), bus.dec_ready, 1'b0);
         if (bus.bit_ready) j++;
         cyc++;
         @(negedge clk);
      end
      check("bits drained", j, DEPTH);
      if (rmode == R_ALWAYS) check("drain cycles", cyc, DEPTH);
      bus.bit_ready = 1'b0;
      check("after frame {busy,bit_valid,dec_ready,active}",
            {bus.busy, bus.bit_valid, bus.dec_ready, bus.tb_active}, 4'b0010);
   endtask

   task automatic run_frame(input vec_t v);
      fill_frame(v.fill);
      frame_start = (v.fill == D_RAND) ? 6'($urandom) : v.start;
      build_model();
      exp_bits = v.use_model ? model_bits : v.exp_bits;
      send_frame(v.hold);
      check_trace();
      recv_bits(v.rmode);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      vecs[0] = '{D_ZERO, 6'h00, R_ALWAYS, 1'b0, 1'b0, 32'h0000_0000};
      vecs[1] = '{D_ONE,  6'h3F, R_ALWAYS, 1'b0, 1'b0, 32'hFFFF_FFFF};
      vecs[2] = '{D_ZERO, 6'h20, R_ALWAYS, 1'b0, 1'b0, 32'h8000_0000};
      vecs[3] = '{D_ONE,  6'h00, R_TOGGLE, 1'b0, 1'b0, 32'h03FF_FFFF};
      vecs[4] = '{D_ZERO, 6'h3F, R_TOGGLE, 1'b0, 1'b0, 32'hFC00_0000};
      vecs[5] = '{D_RAND, 6'h00, R_ALWAYS, 1'b1, 1'b1, 32'h0};
      vecs[6] = '{D_RAND, 6'h00, R_RAND,   1'b1, 1'b1, 32'h0};

      bus.dec_valid   = 1'b0;
      bus.dec_in      = '0;
      bus.start_state = '0;
      bus.bit_ready   = 1'b0;

      #12;
      check("reset {dec_ready,tb_active,bit_valid,bit_out,bit_last,busy}",
            {bus.dec_ready, bus.tb_active, bus.bit_valid, bus.bit_out, bus.bit_last, bus.busy},
            6'b000000);
      check("reset tb_state", bus.tb_state, 6'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("dec_ready after reset release", bus.dec_ready, 1'b1);

      for (int v = 0; v < 7; v++) run_frame(vecs[v]);

      // Reset in the middle of TRACE, then a full frame must still decode.
      fill_frame(D_RAND);
      frame_start = 6'($urandom);
      build_model();
      send_frame(1'b0);
      repeat (10) @(negedge clk);
      check("tb_active at trace cycle 10", bus.tb_active, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid-op reset {busy,bit_valid,tb_active,dec_ready}",
            {bus.busy, bus.bit_valid, bus.tb_active, bus.dec_ready}, 4'b0000);
      bus.dec_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("dec_ready after mid-op reset", bus.dec_ready, 1'b1);
      check("busy after mid-op reset", bus.busy, 1'b0);
      run_frame(vecs[5]);

      for (int n = 0; n < 4; n++) begin
         rv       = vecs[6];
         rv.hold  = 1'($urandom_range(1));
         rv.rmode = rmode_t'($urandom_range(2));
         run_frame(rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
